// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO slice: system clock rate,
// baud accumulator width, FSM state type and pointer sizing helper.
package uart_tx_fifo_pkg;

    localparam int SYS_CLOCK_HZ = 50_000_000;
    localparam int BAUD_ACC_W   = 29;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } tx_state_e;

    // Pointers carry one extra wrap bit above the storage index.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus-side push port and uart-side strobe port of the transmit FIFO.
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int CNT_W = ptr_width(DEPTH);

    logic             wr_en_i;
    logic [7:0]       wr_dat_i;
    logic             ovf_clr_i;
    logic             full_o;
    logic             empty_o;
    logic [CNT_W-1:0] count_o;
    logic             ovf_o;
    logic             busy_o;
    logic             uart_wr_o;
    logic [7:0]       uart_dat_o;

    modport master (
        output wr_en_i, wr_dat_i, ovf_clr_i,
        input  full_o, empty_o, count_o, ovf_o, busy_o, uart_wr_o, uart_dat_o
    );

    modport slave (
        input  wr_en_i, wr_dat_i, ovf_clr_i,
        output full_o, empty_o, count_o, ovf_o, busy_o, uart_wr_o, uart_dat_o
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Fractional baud-rate tick generator; shared with the uart transmitter and
// a future receiver so all of them agree on the exact bit rate.
module uart_baud_tick #(
    parameter int BAUD         = 115200,
    parameter int SYS_CLOCK_HZ = uart_tx_fifo_pkg::SYS_CLOCK_HZ
) (
    input  logic sys_clk_i,
    input  logic sys_rstn_i,
    output logic tick_o
);
    localparam int W = uart_tx_fifo_pkg::BAUD_ACC_W;

    localparam logic [W-1:0] STEP_UP   = W'(BAUD);
    localparam logic [W-1:0] STEP_DOWN = W'(BAUD - SYS_CLOCK_HZ);

    logic [W-1:0] d;

    // A non-negative accumulator marks a tick and pays back one system period.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            d <= '0;
        end else begin
            d <= d + (d[W-1] ? STEP_UP : STEP_DOWN);
        end
    end

    assign tick_o = ~d[W-1];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the uart transmitter: pops one byte at a time and
// spaces write strobes by GAP_TICKS baud ticks so a frame is never cut short.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int BAUD      = 115200,
    parameter int GAP_TICKS = 12
) (
    input  logic           sys_clk_i,
    input  logic           sys_rstn_i,
    uart_tx_fifo_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int GAP_W = $clog2(GAP_TICKS + 1);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             tick;
    logic             ovf;
    tx_state_e        state;
    logic [GAP_W-1:0] gap_cnt;
    logic             uart_wr;
    logic [7:0]       uart_dat;

    uart_baud_tick #(
        .BAUD         (BAUD),
        .SYS_CLOCK_HZ (SYS_CLOCK_HZ)
    ) u_baud_tick (
        .sys_clk_i  (sys_clk_i),
        .sys_rstn_i (sys_rstn_i),
        .tick_o     (tick)
    );

    assign empty = (wptr == rptr);
    assign full  = (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]) && (wptr[IDX_W] != rptr[IDX_W]);
    assign push  = bus.wr_en_i && !full;
    assign pop   = (state == ST_IDLE) && !empty;

    // Storage is deliberately left out of reset; stale bytes are unreachable while empty.
    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem[wptr[IDX_W-1:0]] <= bus.wr_dat_i;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
        end
    end

    // A dropped push takes priority over a clear in the same cycle.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            ovf <= 1'b0;
        end else if (bus.wr_en_i && full) begin
            ovf <= 1'b1;
        end else if (bus.ovf_clr_i) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state    <= ST_IDLE;
            gap_cnt  <= '0;
            uart_wr  <= 1'b0;
            uart_dat <= 8'h00;
        end else begin
            uart_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        uart_dat <= mem[rptr[IDX_W-1:0]];
                        uart_wr  <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    gap_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tick) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                        if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.full_o     = full;
    assign bus.empty_o    = empty;
    assign bus.count_o    = wptr - rptr;
    assign bus.ovf_o      = ovf;
    assign bus.busy_o     = !empty || (state != ST_IDLE);
    assign bus.uart_wr_o  = uart_wr;
    assign bus.uart_dat_o = uart_dat;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed vector table, hand-written
// corner sequences and random pushes checked against a byte-queue timing model.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int DEPTH     = 16;
    localparam int GAP_TICKS = 12;
    localparam int TICK_DIV  = 4;
    localparam int BAUD      = SYS_CLOCK_HZ / TICK_DIV;

    logic sys_clk_i  = 1'b0;
    logic sys_rstn_i = 1'b0;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(
        .DEPTH     (DEPTH),
        .BAUD      (BAUD),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .sys_clk_i  (sys_clk_i),
        .sys_rstn_i (sys_rstn_i),
        .bus        (bus)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int checks   = 0;
    int failures = 0;
    int drv_cyc  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at t=%0t: actual=%0d expected=%0d", name, $time, actual, expected);
        end
    endtask

    // Reference model: a queue of accepted bytes plus the cycle window in which
    // the transmitter is occupied; ticks fall on every TICK_DIV-th cycle after reset.
    bit         model_on = 1'b0;
    int         cyc;
    logic [7:0] m_q [$];
    bit         m_ovf;
    bit         m_wr;
    logic [7:0] m_dat;
    int         idle_from;
    int         busy_from;
    int         busy_to;
    bit         m_pop;
    bit         m_full;
    int         m_t12;

    function automatic void model_reset();
        cyc       = 0;
        m_q.delete();
        m_ovf     = 1'b0;
        m_wr      = 1'b0;
        m_dat     = 8'h00;
        idle_from = 0;
        busy_from = 1;
        busy_to   = 0;
    endfunction

    always @(negedge sys_clk_i) begin
        if (model_on) begin
            checkOutput("model_count", int'(bus.count_o), m_q.size());
            checkOutput("model_empty", int'(bus.empty_o), int'(m_q.size() == 0));
            checkOutput("model_full",  int'(bus.full_o),  int'(m_q.size() == DEPTH));
            checkOutput("model_ovf",   int'(bus.ovf_o),   int'(m_ovf));
            checkOutput("model_busy",  int'(bus.busy_o),
                        int'((m_q.size() > 0) || (cyc >= busy_from && cyc <= busy_to)));
            checkOutput("model_uart_wr",  int'(bus.uart_wr_o),  int'(m_wr));
            checkOutput("model_uart_dat", int'(bus.uart_dat_o), int'(m_dat));

            m_full = (m_q.size() == DEPTH);
            m_pop  = (m_q.size() > 0) && (cyc >= idle_from);
            m_wr   = m_pop;
            if (m_pop) begin
                m_dat     = m_q.pop_front();
                m_t12     = ((cyc + 2 + TICK_DIV - 1) / TICK_DIV) * TICK_DIV
                            + TICK_DIV * (GAP_TICKS - 1);
                busy_from = cyc + 1;
                busy_to   = m_t12;
                idle_from = m_t12 + 1;
            end
            if (bus.wr_en_i && !m_full) begin
                m_q.push_back(bus.wr_dat_i);
            end
            if (bus.wr_en_i && m_full) begin
                m_ovf = 1'b1;
            end else if (bus.ovf_clr_i) begin
                m_ovf = 1'b0;
            end
            cyc++;
        end
    end

    task automatic applyStimulus(input bit wr, input logic [7:0] dat, input bit clr);
        bus.wr_en_i   = wr;
        bus.wr_dat_i  = dat;
        bus.ovf_clr_i = clr;
        @(posedge sys_clk_i);
        #1;
        drv_cyc++;
    endtask

    task automatic idle_until(input int target);
        while (drv_cyc < target) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_count"},    int'(bus.count_o),    0);
        checkOutput({tag, "_empty"},    int'(bus.empty_o),    1);
        checkOutput({tag, "_full"},     int'(bus.full_o),     0);
        checkOutput({tag, "_ovf"},      int'(bus.ovf_o),      0);
        checkOutput({tag, "_busy"},     int'(bus.busy_o),     0);
        checkOutput({tag, "_uart_wr"},  int'(bus.uart_wr_o),  0);
        checkOutput({tag, "_uart_dat"}, int'(bus.uart_dat_o), 0);
    endtask

    // Asserts reset a little after a clock edge, checks the asynchronous
    // response, then releases so that cycle 0 starts at the following edge.
    task automatic do_reset(input string tag);
        model_on      = 1'b0;
        bus.wr_en_i   = 1'b0;
        bus.wr_dat_i  = 8'h00;
        bus.ovf_clr_i = 1'b0;
        sys_rstn_i    = 1'b0;
        #2;
        check_reset_values(tag);
        repeat (2) @(posedge sys_clk_i);
        #1;
        sys_rstn_i = 1'b1;
        model_reset();
        model_on = 1'b1;
        drv_cyc  = 0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.busy_o && n < limit) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            n++;
        end
        checkOutput("drain_timeout_busy", int'(bus.busy_o), 0);
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] dat;
        bit         clr;
        int         exp_count;
        bit         exp_empty;
        bit         exp_wr;
        logic [7:0] exp_dat;
        bit         exp_busy;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int strobes;
        int rates [6];
        rates = '{5, 50, 95, 2, 70, 20};

        bus.wr_en_i   = 1'b0;
        bus.wr_dat_i  = 8'h00;
        bus.ovf_clr_i = 1'b0;
        #1;

        // Single byte: strobe two cycles after the push, busy until the 12th tick.
        vecs[0] = '{1'b1, 8'h41, 1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b1, 8'h41, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'h41, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'h41, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h41, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'h41, 1'b1};

        do_reset("reset0");
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("vec%0d_count", i),    int'(bus.count_o),    vecs[i].exp_count);
            checkOutput($sformatf("vec%0d_empty", i),    int'(bus.empty_o),    int'(vecs[i].exp_empty));
            checkOutput($sformatf("vec%0d_uart_wr", i),  int'(bus.uart_wr_o),  int'(vecs[i].exp_wr));
            checkOutput($sformatf("vec%0d_uart_dat", i), int'(bus.uart_dat_o), int'(vecs[i].exp_dat));
            checkOutput($sformatf("vec%0d_busy", i),     int'(bus.busy_o),     int'(vecs[i].exp_busy));
            applyStimulus(vecs[i].wr, vecs[i].dat, vecs[i].clr);
        end
        idle_until(48);
        checkOutput("single_busy_at_48", int'(bus.busy_o), 1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("single_busy_at_49", int'(bus.busy_o), 0);

        // Sixteen back-to-back bytes never fill the FIFO since the first pops at once.
        do_reset("reset1");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            checkOutput($sformatf("burst16_full_%0d", i), int'(bus.full_o), 0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        wait_idle(2000);

        // Overflow while the FSM waits, clear, and overflow racing a clear.
        do_reset("reset2");
        applyStimulus(1'b1, 8'h0A, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
        end
        checkOutput("fill_count",     int'(bus.count_o), 16);
        checkOutput("fill_full",      int'(bus.full_o),  1);
        checkOutput("fill_ovf",       int'(bus.ovf_o),   0);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        checkOutput("drop_ovf",       int'(bus.ovf_o),   1);
        checkOutput("drop_count",     int'(bus.count_o), 16);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("clr_ovf",        int'(bus.ovf_o),   0);
        applyStimulus(1'b1, 8'hFE, 1'b1);
        checkOutput("set_beats_clr",  int'(bus.ovf_o),   1);
        checkOutput("set_beats_clr_count", int'(bus.count_o), 16);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("clr_again_ovf",  int'(bus.ovf_o),   0);
        idle_until(49);
        checkOutput("full_before_pop", int'(bus.full_o), 1);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        checkOutput("full_push_with_pop_ovf",   int'(bus.ovf_o),      1);
        checkOutput("full_push_with_pop_count", int'(bus.count_o),    15);
        checkOutput("full_pop_uart_wr",         int'(bus.uart_wr_o),  1);
        checkOutput("full_pop_uart_dat",        int'(bus.uart_dat_o), 8'h10);
        wait_idle(2000);

        // Simultaneous push and pop at five entries.
        do_reset("reset3");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
        end
        idle_until(49);
        checkOutput("pushpop_count_before", int'(bus.count_o), 5);
        applyStimulus(1'b1, 8'h36, 1'b0);
        checkOutput("pushpop_count_after", int'(bus.count_o),    5);
        checkOutput("pushpop_uart_wr",     int'(bus.uart_wr_o),  1);
        checkOutput("pushpop_uart_dat",    int'(bus.uart_dat_o), 8'h31);
        wait_idle(2000);

        // Random pushes at varying load, checked cycle by cycle by the model.
        do_reset("reset4");
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 500; i++) begin
                applyStimulus($urandom_range(0, 99) < rates[b], 8'($urandom),
                              $urandom_range(0, 99) < 4);
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        wait_idle(2000);

        // Reset in the middle of WAIT with three bytes still queued.
        do_reset("reset5");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h71 + i), 1'b0);
        end
        idle_until(10);
        checkOutput("midwait_count", int'(bus.count_o), 3);
        do_reset("midwait_reset");
        strobes = 0;
        for (int i = 0; i < 120; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            if (bus.uart_wr_o) begin
                strobes++;
            end
        end
        checkOutput("no_strobe_after_reset", strobes, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, 16, FIFO entries (power of two, 2..256).
REQ-002 Parameter BAUD, 115200, serial bit rate in Hz.
REQ-003 Parameter GAP_TICKS, 12, baud ticks to wait after each uart_wr_o pulse before the next pop.
REQ-004 sys_clk_i  in  1  single system clock; all state on rising edge.
REQ-005 sys_rstn_i  in  1  reset, asynchronous, active-low.
REQ-006 wr_en_i  in  1  push strobe from CPU/bus, one byte per asserted cycle.
REQ-007 wr_dat_i  in  8  byte to push.
REQ-008 ovf_clr_i  in  1  clears sticky overflow flag.
REQ-009 full_o  out  1  FIFO holds DEPTH entries.
REQ-010 empty_o  out  1  FIFO holds 0 entries.
REQ-011 count_o  out  log2(DEPTH)+1  current occupancy.
REQ-012 ovf_o  out  1  sticky: a push was dropped.
REQ-013 busy_o  out  1  FIFO non-empty or FSM not IDLE.
REQ-014 uart_wr_o  out  1  one-cycle write strobe to the downstream uart block.
REQ-015 uart_dat_o  out  8  byte presented to uart; valid on the uart_wr_o cycle.

Function
REQ-016 Storage: DEPTH x 8 circular buffer; read/write pointers are log2(DEPTH)+1 bits wide, with the MSB as the wrap bit; full = equal indices with differing MSB; empty = equal pointers.
REQ-017 Push: wr_en_i && !full_o writes wr_dat_i at wptr and increments wptr, wrapping naturally at DEPTH.
REQ-018 Push while full: the byte is dropped, pointers are unchanged, and ovf_o is set the next cycle.
REQ-019 Full status is evaluated before a same-cycle pop; a push to a full FIFO is dropped even if a pop occurs that cycle.
REQ-020 Simultaneous push and pop on a non-full, non-empty FIFO: both occur and count_o is unchanged.
REQ-021 ovf_o: set wins over ovf_clr_i in the same cycle; otherwise ovf_clr_i clears it.
REQ-022 Baud tick: 29-bit accumulator d; increment = BAUD when d[28]=1, else BAUD-SYS_CLOCK_HZ; tick = ~d[28]; this matches the uart block's rate exactly.
REQ-023 FSM states: IDLE, SEND, WAIT.
REQ-024 IDLE: if !empty, pop the head into uart_dat_o and go to SEND; else stay in IDLE.
REQ-025 SEND: uart_wr_o=1 for exactly this one cycle; clear the gap counter; go to WAIT.
REQ-026 WAIT: increment the gap counter on each tick; when it reaches GAP_TICKS, go to IDLE.
REQ-027 Latency: a push into an empty, idle FIFO produces uart_wr_o 2 cycles later (push cycle, pop cycle, strobe cycle).
REQ-028 Strobe spacing: consecutive uart_wr_o pulses are at least GAP_TICKS baud ticks + 2 cycles apart; with GAP_TICKS >= 12, the uart block is never written while busy with an 11-tick frame.
REQ-029 uart_dat_o holds its value between pops.
REQ-030 uart_wr_o is never asserted in IDLE or WAIT.

Reset
REQ-031 Asserting sys_rstn_i low at any time, including mid-WAIT, immediately resets all of the following: pointers=0, FSM=IDLE, gap counter=0, d=0, uart_wr_o=0, uart_dat_o=8'h00, ovf_o=0, empty_o=1, full_o=0, count_o=0, busy_o=0.
REQ-032 FIFO storage contents are not reset; they are unobservable while empty.
REQ-033 A byte popped before a mid-frame reset is lost; no retransmission occurs.

Structure
REQ-034 SYS_CLOCK_HZ comes from the shared define header.
REQ-035 The FSM state encodings are local parameters.
REQ-036 The baud accumulator is a sub-module uart_baud_tick (params BAUD, SYS_CLOCK_HZ; output tick_o), reusable by the uart block and a future receiver.
REQ-037 The implementation is sized at roughly 150-250 lines of RTL.

Verification
REQ-038 Reset, then push 8'h41 once: uart_wr_o pulses 2 cycles later with uart_dat_o=8'h41; busy_o drops after 12 ticks.
REQ-039 Push 16 bytes 8'h00..8'h0F back-to-back: full_o is never set (first byte popped); strobes carry 00..0F in order, each spaced >= 12 ticks; the serialized uart_tx line decodes to the same bytes.
REQ-040 Hold the FSM in WAIT, fill to 16, then push 8'hFF: byte dropped, ovf_o=1, count_o=16; ovf_clr_i pulse -> ovf_o=0; simultaneous overflow and clear -> ovf_o=1.
REQ-041 Simultaneous push and pop at count_o=5: count_o remains 5; data order is preserved across the pointer wrap after 20 pushes.
REQ-042 Assert sys_rstn_i mid-WAIT with 3 bytes queued: all outputs take reset values within the reset assertion; after release, no uart_wr_o occurs until a new push.
